// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: S-box, round constants and the
// sequencer state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } key_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Indices outside 1..10 only occur on steps that are never committed.
  function automatic logic [7:0] rcon_at(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

endpackage

// File: rtl/inv_gen_keys_key_round_step.sv
// One AES-128 key-schedule round, forward or inverse, with a single shared
// SubWord(RotWord()) stage.
module key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic         fwd_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, rot, sub, t;

  always_comb begin
    w0 = key_i[127:96];
    w1 = key_i[95:64];
    w2 = key_i[63:32];
    w3 = key_i[31:0];
    // Inverse recovers the previous w3 as w3^w2 before it feeds SubWord.
    sw_in = fwd_i ? w3 : (w3 ^ w2);
    rot   = {sw_in[23:0], sw_in[31:24]};
    sub   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t     = sub ^ {rcon_i, 24'h0};
    if (fwd_i) begin
      key_o[127:96] = w0 ^ t;
      key_o[95:64]  = w1 ^ w0 ^ t;
      key_o[63:32]  = w2 ^ w1 ^ w0 ^ t;
      key_o[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
    end else begin
      key_o[127:96] = w0 ^ t;
      key_o[95:64]  = w1 ^ w0;
      key_o[63:32]  = w2 ^ w1;
      key_o[31:0]   = w3 ^ w2;
    end
  end

endmodule

// File: rtl/inv_gen_keys.sv
// Round-key sequencer for AES-128 decryption: expands to K10, then walks the
// key schedule up or down one round per cycle toward the requested round.
module inv_gen_keys #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_doing,
  input  logic [127:0] rx_key,
  input  logic [3:0]   cur_round,
  output logic [127:0] cur_key,
  output logic         key_valid,
  output logic         done
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_POS = 4'(NUM_ROUNDS);

  key_state_t   state_q;
  logic [3:0]   pos_q;
  logic [127:0] key_q;
  logic         done_q;

  logic         walk_dn, walk_up, step_fwd;
  logic [7:0]   step_rcon;
  logic [127:0] key_d;

  always_comb begin
    walk_dn   = (state_q == READY) && (cur_round < pos_q);
    walk_up   = (state_q == READY) && (cur_round > pos_q) && (cur_round <= LAST_POS);
    step_fwd  = !walk_dn;
    step_rcon = walk_dn ? rcon_at(pos_q) : rcon_at(pos_q + 4'd1);
  end

  key_round_step u_step (
    .key_i  (key_q),
    .rcon_i (step_rcon),
    .fwd_i  (step_fwd),
    .key_o  (key_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else if (start_doing) begin
      state_q <= EXPAND;
      pos_q   <= 4'd0;
      key_q   <= rx_key;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          key_q <= key_d;
          pos_q <= pos_q + 4'd1;
          if (pos_q == LAST_POS - 4'd1) begin
            state_q <= READY;
            done_q  <= 1'b1;
          end
        end
        READY: begin
          if (walk_dn) begin
            key_q <= key_d;
            pos_q <= pos_q - 4'd1;
          end else if (walk_up) begin
            key_q <= key_d;
            pos_q <= pos_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_valid = (state_q == READY) && (pos_q == cur_round);
  assign cur_key   = key_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_gen_keys.sv
// Directed bench for inv_gen_keys with an independent FIPS-197 style key
// expansion model feeding a scoreboard of expected round keys.
module tb_inv_gen_keys;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start_doing;
  logic [127:0] rx_key;
  logic [3:0]   cur_round;
  logic [127:0] cur_key;
  logic         key_valid, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] rk_m [0:10];
  logic [127:0] sbq [$];

  localparam logic [127:0] KEY_A   = 128'h68656c6c6f3030303030303030303030;
  localparam logic [127:0] KEY_A10 = 128'h0043de6459c9e24b5a4ebb8add080009;
  localparam logic [127:0] KEY_A1  = 128'h6d616868025158583261686802515858;
  localparam logic [127:0] KEY_F   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_F10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  inv_gen_keys dut (
    .clk         (clk),
    .rst         (rst),
    .start_doing (start_doing),
    .rx_key      (rx_key),
    .cur_round   (cur_round),
    .cur_key     (cur_key),
    .key_valid   (key_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-array expansion, independent of the DUT's register stepping.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc [1:10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        tmp = tmp ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load(input logic [127:0] k);
    rx_key = k;
    start_doing = 1'b1;
    tick();
    start_doing = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt = 0;
    while (!done && cnt < 20) begin
      tick();
      cnt++;
    end
    chk(tag, 128'(cnt), 128'd10);
  endtask

  initial begin
    int vcnt;
    logic [127:0] e;
    rst = 1'b1; start_doing = 1'b0; rx_key = '0; cur_round = 4'd10;
    tick(); tick();
    chk("reset_key", cur_key, 128'h0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_valid", 128'(key_valid), 128'd0);
    rst = 1'b0;

    // Load key A and expand
    build_model(KEY_A);
    chk("model_k10", rk_m[10], KEY_A10);
    load(KEY_A);
    chk("load_key", cur_key, KEY_A);
    chk("load_done", 128'(done), 128'd0);
    wait_done("expand_latency");
    chk("k10", cur_key, KEY_A10);
    chk("k10_valid", 128'(key_valid), 128'd1);

    // Backward sweep 9..0 through the scoreboard
    for (int r = 9; r >= 0; r--) begin
      cur_round = 4'(r);
      sbq.push_back(rk_m[r]);
      tick();
      chk($sformatf("sweep_valid_r%0d", r), 128'(key_valid), 128'd1);
      if (key_valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("sweep_key_r%0d", r), cur_key, e);
      end
      if (r == 1) chk("round1_const", cur_key, KEY_A1);
    end
    chk("round0_is_rx", cur_key, KEY_A);
    chk("sb_drained", 128'(sbq.size()), 128'd0);

    // Jump from round 0 to round 10
    cur_round = 4'd10;
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (key_valid) vcnt++;
    end
    chk("jump_no_early_valid", 128'(vcnt), 128'd0);
    tick();
    chk("jump_valid", 128'(key_valid), 128'd1);
    chk("jump_k10", cur_key, KEY_A10);

    // Out-of-range request holds position
    cur_round = 4'd13;
    tick(); tick(); tick();
    chk("oor_valid", 128'(key_valid), 128'd0);
    chk("oor_hold_key", cur_key, KEY_A10);
    cur_round = 4'd10;
    #1;
    chk("oor_pos_held", 128'(key_valid), 128'd1);

    // Restart mid-expand with the FIPS-197 key
    load(KEY_A);
    repeat (5) tick();
    chk("mid_expand_k5", cur_key, rk_m[5]);
    build_model(KEY_F);
    load(KEY_F);
    chk("restart_key", cur_key, KEY_F);
    chk("restart_done", 128'(done), 128'd0);
    wait_done("restart_latency");
    chk("fips_k10", cur_key, KEY_F10);
    chk("fips_k10_model", cur_key, rk_m[10]);

    // Retarget mid-walk, then reset mid-walk
    cur_round = 4'd2;
    tick(); tick(); tick();
    chk("walk_k7", cur_key, rk_m[7]);
    cur_round = 4'd8;
    tick();
    chk("retarget_k8", cur_key, rk_m[8]);
    chk("retarget_valid", 128'(key_valid), 128'd1);
    cur_round = 4'd3;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_walk_key", cur_key, 128'h0);
    chk("rst_walk_done", 128'(done), 128'd0);
    chk("rst_walk_valid", 128'(key_valid), 128'd0);
    rst = 1'b0;
    cur_round = 4'd0;
    tick(); tick();
    chk("idle_ignore_valid", 128'(key_valid), 128'd0);
    chk("idle_ignore_key", cur_key, 128'h0);

    // Reset in READY and mid-expand
    load(KEY_F);
    wait_done("reload_latency");
    rst = 1'b1;
    tick();
    chk("rst_ready_done", 128'(done), 128'd0);
    chk("rst_ready_key", cur_key, 128'h0);
    rst = 1'b0;
    load(KEY_A);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_expand_key", cur_key, 128'h0);
    cur_round = 4'd10;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || key_valid) vcnt++;
    end
    chk("rst_expand_stays_idle", 128'(vcnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
